// File: rtl/branch_ctrl_if.sv
// Branch-resolution bus between the branch ALU, the fetch redirect port and
// the branch controller, plus predictor-update and statistics outputs.
interface branch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic            alu_req;
    logic [XLEN-1:0] alu_jmp;
    logic [XLEN-1:0] alu_pc;
    logic            alu_is_branch;
    logic            alu_mispredict;
    logic            alu_i_error;
    logic            alu_o_error;
    logic            redir_ready;

    logic            alu_clear;
    logic            flush;
    logic            stall_issue;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            exc_valid;
    logic [1:0]      exc_cause;
    logic            bp_upd_valid;
    logic [XLEN-1:0] bp_upd_pc;
    logic            bp_upd_taken;
    logic [31:0]     br_cnt;
    logic [31:0]     mp_cnt;

    // The branch controller side.
    modport slave (
        input  alu_valid, alu_req, alu_jmp, alu_pc, alu_is_branch,
               alu_mispredict, alu_i_error, alu_o_error, redir_ready,
        output alu_clear, flush, stall_issue, redir_valid, redir_pc,
               exc_valid, exc_cause, bp_upd_valid, bp_upd_pc, bp_upd_taken,
               br_cnt, mp_cnt
    );

    // The pipeline side: branch ALU and fetch unit.
    modport master (
        output alu_valid, alu_req, alu_jmp, alu_pc, alu_is_branch,
               alu_mispredict, alu_i_error, alu_o_error, redir_ready,
        input  alu_clear, flush, stall_issue, redir_valid, redir_pc,
               exc_valid, exc_cause, bp_upd_valid, bp_upd_pc, bp_upd_taken,
               br_cnt, mp_cnt
    );
endinterface

// File: rtl/branch_ctrl.sv
// Branch resolution controller: captures branch-ALU outcomes, flushes and
// redirects fetch on mispredicts or traps, and keeps branch statistics.
module branch_ctrl #(
    parameter int              XLEN         = 32,
    parameter int              FLUSH_CYCLES = 2,
    parameter logic [XLEN-1:0] TRAP_VEC     = XLEN'(32'h0000_0100)
) (
    input logic          clk,
    input logic          rst_n,
    branch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t          state;
    logic [3:0]      flush_cnt_q;
    logic [XLEN-1:0] target_q;

    logic            alu_clear_q;
    logic            flush_q;
    logic            stall_q;
    logic            redir_valid_q;
    logic [XLEN-1:0] redir_pc_q;
    logic            exc_valid_q;
    logic [1:0]      exc_cause_q;
    logic            bp_upd_valid_q;
    logic [XLEN-1:0] bp_upd_pc_q;
    logic            bp_upd_taken_q;
    logic [31:0]     br_cnt_q;
    logic [31:0]     mp_cnt_q;

    logic            capture;
    logic            err;
    logic            go_flush;
    logic            count_br;
    logic [1:0]      cause;
    logic [XLEN-1:0] cap_target;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        capture    = 1'b0;
        err        = 1'b0;
        go_flush   = 1'b0;
        count_br   = 1'b0;
        cause      = 2'b00;
        cap_target = '0;
        if (state == IDLE) begin
            capture = bus.alu_valid || bus.alu_i_error;
        end
        err      = bus.alu_i_error || bus.alu_o_error;
        go_flush = err || bus.alu_mispredict;
        count_br = bus.alu_is_branch && !err;
        // Illegal instruction outranks overflow when both are flagged.
        cause = bus.alu_i_error ? 2'b01 : 2'b10;
        if (err) begin
            cap_target = TRAP_VEC;
        end else if (bus.alu_req) begin
            cap_target = bus.alu_jmp;
        end else begin
            cap_target = bus.alu_pc + XLEN'(4);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            flush_cnt_q    <= '0;
            target_q       <= '0;
            alu_clear_q    <= 1'b0;
            flush_q        <= 1'b0;
            stall_q        <= 1'b0;
            redir_valid_q  <= 1'b0;
            redir_pc_q     <= '0;
            exc_valid_q    <= 1'b0;
            exc_cause_q    <= 2'b00;
            bp_upd_valid_q <= 1'b0;
            bp_upd_pc_q    <= '0;
            bp_upd_taken_q <= 1'b0;
            br_cnt_q       <= '0;
            mp_cnt_q       <= '0;
        end else begin
            alu_clear_q    <= 1'b0;
            exc_valid_q    <= 1'b0;
            exc_cause_q    <= 2'b00;
            bp_upd_valid_q <= 1'b0;
            bp_upd_pc_q    <= '0;
            bp_upd_taken_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (capture) begin
                        alu_clear_q <= 1'b1;
                        if (count_br) begin
                            bp_upd_valid_q <= 1'b1;
                            bp_upd_pc_q    <= bus.alu_pc;
                            bp_upd_taken_q <= bus.alu_req;
                            br_cnt_q       <= br_cnt_q + 32'd1;
                            if (bus.alu_mispredict) begin
                                mp_cnt_q <= mp_cnt_q + 32'd1;
                            end
                        end
                        if (err) begin
                            exc_valid_q <= 1'b1;
                            exc_cause_q <= cause;
                        end
                        if (go_flush) begin
                            target_q    <= cap_target;
                            flush_cnt_q <= FLUSH_LAST;
                            flush_q     <= 1'b1;
                            stall_q     <= 1'b1;
                            state       <= FLUSH;
                        end
                    end
                end

                FLUSH: begin
                    if (flush_cnt_q == 4'd0) begin
                        flush_q       <= 1'b0;
                        redir_valid_q <= 1'b1;
                        redir_pc_q    <= target_q;
                        state         <= REDIRECT;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end

                REDIRECT: begin
                    // Stall drops together with the request once fetch accepts it.
                    if (bus.redir_ready) begin
                        redir_valid_q <= 1'b0;
                        redir_pc_q    <= '0;
                        stall_q       <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alu_clear    = alu_clear_q;
    assign bus.flush        = flush_q;
    assign bus.stall_issue  = stall_q;
    assign bus.redir_valid  = redir_valid_q;
    assign bus.redir_pc     = redir_pc_q;
    assign bus.exc_valid    = exc_valid_q;
    assign bus.exc_cause    = exc_cause_q;
    assign bus.bp_upd_valid = bp_upd_valid_q;
    assign bus.bp_upd_pc    = bp_upd_pc_q;
    assign bus.bp_upd_taken = bp_upd_taken_q;
    assign bus.br_cnt       = br_cnt_q;
    assign bus.mp_cnt       = mp_cnt_q;
endmodule
